// File: rtl/audio_i2s_tx.sv
// Purpose : stereo I2S transmitter; single-entry sample holding buffer, internally divided BCLK/LRCK,
//           MSB-first serialisation one BCLK after each LRCK edge, repeats last frame when starved.
// Latency : sample_valid -> MSB on oAUD_DACDAT between 2*BCLK_DIV cycles and one frame + 2*BCLK_DIV cycles.
// Backpressure: none; a second sample before the next frame load overwrites the held one (overrun pulse),
//               a frame load with nothing held resends the previous frame (underrun pulse).
//
// Ports:
//   sCLK_XVXENVS  in   engine clock, all logic on posedge
//   iRST_N        in   asynchronous active-low reset
//   lsound_in     in   left sample (two's complement), captured on sample_valid
//   rsound_in     in   right sample (two's complement), captured on sample_valid
//   sample_valid  in   one-cycle strobe
//   oAUD_BCLK     out  bit clock, 2*BCLK_DIV clk cycles per period
//   oAUD_DACLRCK  out  word select, 0 = left slot
//   oAUD_DACDAT   out  serial data, changes with the falling BCLK
//   frame_start   out  one-cycle pulse on each frame load
//   overrun       out  one-cycle pulse, the cycle after a held sample was overwritten
//   underrun      out  one-cycle pulse on a frame load that repeats the previous frame

`ifdef _24BitAudio
`define AUDIO_I2S_TX_DEF_DW 24
`else
`define AUDIO_I2S_TX_DEF_DW 16
`endif

module audio_i2s_tx #(
    parameter int DATA_WIDTH = `AUDIO_I2S_TX_DEF_DW,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  sCLK_XVXENVS,
    input  logic                  iRST_N,
    input  logic [DATA_WIDTH-1:0] lsound_in,
    input  logic [DATA_WIDTH-1:0] rsound_in,
    input  logic                  sample_valid,
    output logic                  oAUD_BCLK,
    output logic                  oAUD_DACLRCK,
    output logic                  oAUD_DACDAT,
    output logic                  frame_start,
    output logic                  overrun,
    output logic                  underrun
);

    // Bit-position counter spans both slots of a frame.
    localparam int PW = $clog2(2 * SLOT_WIDTH);
    // Divider counter width; a BCLK_DIV of 2 still needs one bit.
    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST    = PW'(2 * SLOT_WIDTH - 1);
    localparam logic [PW-1:0] P_SLOT    = PW'(SLOT_WIDTH);
    localparam logic [PW-1:0] P_L_FIRST = PW'(1);
    localparam logic [PW-1:0] P_L_LAST  = PW'(DATA_WIDTH);
    localparam logic [PW-1:0] P_R_FIRST = PW'(SLOT_WIDTH + 1);
    localparam logic [PW-1:0] P_R_LAST  = PW'(SLOT_WIDTH + DATA_WIDTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(BCLK_DIV - 1);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Clock generation and bit position
    logic [CW-1:0]         r_div_cnt;
    logic                  r_bclk;
    logic [PW-1:0]         r_p;

    // Holding buffer
    buf_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_buf_l;
    logic [DATA_WIDTH-1:0] r_buf_r;

    // Frame currently on the wire (kept whole so a starved load can resend it)
    logic [DATA_WIDTH-1:0] r_frm_l;
    logic [DATA_WIDTH-1:0] r_frm_r;

    // Working shift registers, reloaded from the frame at every load
    logic [DATA_WIDTH-1:0] r_sh_l;
    logic [DATA_WIDTH-1:0] r_sh_r;

    // Registered outputs
    logic                  r_lrck;
    logic                  r_dat;
    logic                  r_frame_start;
    logic                  r_overrun;
    logic                  r_underrun;

    logic                  w_wrap;
    logic                  w_fall;
    logic [PW-1:0]         w_p_next;
    logic                  w_load;
    logic                  w_left_bit;
    logic                  w_right_bit;

    assign w_wrap      = (r_div_cnt == DIV_LAST);
    // A fall is the divider wrap while BCLK is currently high.
    assign w_fall      = w_wrap && r_bclk;
    assign w_p_next    = (r_p == P_LAST) ? '0 : (r_p + PW'(1));
    assign w_load      = w_fall && (w_p_next == '0);
    assign w_left_bit  = (w_p_next >= P_L_FIRST) && (w_p_next <= P_L_LAST);
    assign w_right_bit = (w_p_next >= P_R_FIRST) && (w_p_next <= P_R_LAST);

    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div_cnt     <= '0;
            r_bclk        <= 1'b0;
            r_p           <= P_LAST;
            r_state       <= BUF_EMPTY;
            r_buf_l       <= '0;
            r_buf_r       <= '0;
            r_frm_l       <= '0;
            r_frm_r       <= '0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
            r_lrck        <= 1'b0;
            r_dat         <= 1'b0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            // Pulses are single-cycle by default.
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_underrun    <= 1'b0;

            // BCLK divider
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + CW'(1);
            end

            // Serial side: LRCK and data move only on the falling BCLK,
            // so the DAC sees them stable at the following rise.
            if (w_fall) begin
                r_p    <= w_p_next;
                r_lrck <= (w_p_next >= P_SLOT);
                if (w_left_bit) begin
                    r_dat  <= r_sh_l[DATA_WIDTH-1];
                    r_sh_l <= {r_sh_l[DATA_WIDTH-2:0], 1'b0};
                end else if (w_right_bit) begin
                    r_dat  <= r_sh_r[DATA_WIDTH-1];
                    r_sh_r <= {r_sh_r[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    r_dat  <= 1'b0;
                end
            end

            // Holding buffer and frame load
            if (w_load) begin
                r_frame_start <= 1'b1;
                case (r_state)
                    BUF_FULL: begin
                        r_frm_l <= r_buf_l;
                        r_frm_r <= r_buf_r;
                        r_sh_l  <= r_buf_l;
                        r_sh_r  <= r_buf_r;
                        // A strobe on the load cycle refills the buffer the load just drained.
                        if (sample_valid) begin
                            r_buf_l <= lsound_in;
                            r_buf_r <= rsound_in;
                        end else begin
                            r_state <= BUF_EMPTY;
                        end
                    end
                    default: begin
                        if (sample_valid) begin
                            // Sample arriving exactly at the load bypasses the buffer.
                            r_frm_l <= lsound_in;
                            r_frm_r <= rsound_in;
                            r_sh_l  <= lsound_in;
                            r_sh_r  <= rsound_in;
                        end else begin
                            // Starved: resend the previous frame.
                            r_sh_l     <= r_frm_l;
                            r_sh_r     <= r_frm_r;
                            r_underrun <= 1'b1;
                        end
                    end
                endcase
            end else if (sample_valid) begin
                r_buf_l <= lsound_in;
                r_buf_r <= rsound_in;
                r_state <= BUF_FULL;
                if (r_state == BUF_FULL) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign oAUD_BCLK    = r_bclk;
    assign oAUD_DACLRCK = r_lrck;
    assign oAUD_DACDAT  = r_dat;
    assign frame_start  = r_frame_start;
    assign overrun      = r_overrun;
    assign underrun     = r_underrun;

endmodule

`undef AUDIO_I2S_TX_DEF_DW

// File: tb/tb_audio_i2s_tx.sv
// Purpose : self-checking bench for audio_i2s_tx; reconstructs each serial frame and compares it
//           against a queue of expected frames pushed as samples are driven.
// Covers  : reset state, first-edge timing, single sample, starvation, overrun, load-cycle strobes,
//           asynchronous reset mid-frame.

module tb_audio_i2s_tx;

    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] l_in;
    logic [DW-1:0] r_in;
    logic          sv;
    logic          bclk;
    logic          lrck;
    logic          dat;
    logic          fs;
    logic          orun;
    logic          urun;

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .BCLK_DIV   (DIV)
    ) dut (
        .sCLK_XVXENVS (clk),
        .iRST_N       (rst_n),
        .lsound_in    (l_in),
        .rsound_in    (r_in),
        .sample_valid (sv),
        .oAUD_BCLK    (bclk),
        .oAUD_DACLRCK (lrck),
        .oAUD_DACDAT  (dat),
        .frame_start  (fs),
        .overrun      (orun),
        .underrun     (urun)
    );

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    typedef struct packed {
        int            p;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          push;
    } stim_t;

    frame_t exp_q[$];
    stim_t  stim_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_or     = 0;
    int snap     = 0;
    bit prev_bclk = 1'b0;
    bit fall_now  = 1'b0;

    localparam frame_t F_ZERO = '0;
    localparam frame_t F_A    = {24'h800001, 24'h7FFFFE};
    localparam frame_t F_B1   = {24'h123456, 24'h654321};
    localparam frame_t F_B2   = {24'h0F0F0F, 24'hF0F0F0};
    localparam frame_t F_C    = {24'hABCDEF, 24'h13579B};
    localparam frame_t F_B3   = {24'h5A5A5A, 24'hA5A5A5};
    localparam frame_t F_D    = {24'hA5C3F0, 24'h3C0F5A};
    localparam frame_t F_E    = {24'hC00003, 24'h400002};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample #1 after the edge, drop any strobe the edge just captured.
    task automatic tick();
        @(posedge clk);
        #1;
        sv       = 1'b0;
        cyc++;
        fall_now = prev_bclk && !bclk;
        prev_bclk = bclk;
        if (orun) n_or++;
    endtask

    task automatic drive(input frame_t s);
        sv   = 1'b1;
        l_in = s.l;
        r_in = s.r;
    endtask

    task automatic add_stim(input int p, input frame_t s, input logic push);
        stim_t t;
        t.p    = p;
        t.l    = s.l;
        t.r    = s.r;
        t.push = push;
        stim_q.push_back(t);
    endtask

    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            tick();
            if (fall_now) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called just after a load fall (p=0); consumes falls p=1..2*SW-1.
    task automatic run_frame(input string tag);
        frame_t e;
        frame_t g;
        int     bad_lr;
        int     bad_pad;
        bit     ok;
        stim_t  s;
        g       = '0;
        bad_lr  = 0;
        bad_pad = 0;
        if (exp_q.size() == 0) begin
            check({tag, "_expq_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        for (int p = 1; p < 2 * SW; p++) begin
            wait_fall(ok);
            if (!ok) begin
                check({tag, "_fall_timeout"}, 0, 1);
                return;
            end
            if (lrck !== (p >= SW)) bad_lr++;
            if (p >= 1 && p <= DW) g.l = {g.l[DW-2:0], dat};
            else if (p >= SW + 1 && p <= SW + DW) g.r = {g.r[DW-2:0], dat};
            else if (dat !== 1'b0) bad_pad++;
            if (stim_q.size() > 0 && stim_q[0].p == p) begin
                s = stim_q.pop_front();
                drive({s.l, s.r});
                if (s.push) exp_q.push_back({s.l, s.r});
            end
        end
        check({tag, "_left"}, g.l, e.l);
        check({tag, "_right"}, g.r, e.r);
        check({tag, "_lrck_bad"}, bad_lr, 0);
        check({tag, "_pad_bad"}, bad_pad, 0);
    endtask

    // Called right after the last fall of a frame; handles the next load fall.
    task automatic do_load(input string tag, input bit exp_ur, input bit strobe, input frame_t s);
        bit ok;
        if (strobe) begin
            repeat (2 * DIV - 1) tick();
            drive(s);
            exp_q.push_back(s);
            tick();
            ok = fall_now;
        end else begin
            wait_fall(ok);
        end
        check({tag, "_fall"}, ok, 1);
        check({tag, "_fs"}, fs, 1);
        check({tag, "_ur"}, urun, exp_ur);
        check({tag, "_lrck"}, lrck, 0);
    endtask

    // Releases reset and checks edge timing up to and including the first load.
    task automatic release_check(input string tag, input bit with_sample, input frame_t s);
        rst_n     = 1'b1;
        cyc       = 0;
        prev_bclk = 1'b0;
        for (int k = 1; k <= 2 * DIV; k++) begin
            tick();
            check($sformatf("%s_bclk_e%0d", tag, k), bclk, (k >= DIV && k < 2 * DIV));
            if (k < 2 * DIV) check($sformatf("%s_fs_e%0d", tag, k), fs, 0);
            if (k == DIV && with_sample) begin
                drive(s);
                exp_q.push_back(s);
            end
        end
        check({tag, "_first_fall"}, fall_now, 1);
        check({tag, "_first_fs"}, fs, 1);
        check({tag, "_first_ur"}, urun, !with_sample);
        check({tag, "_first_lrck"}, lrck, 0);
        check({tag, "_first_dat"}, dat, 0);
        if (!with_sample) exp_q.push_back(F_ZERO);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_lrck"}, lrck, 0);
        check({tag, "_dat"}, dat, 0);
        check({tag, "_fs"}, fs, 0);
        check({tag, "_or"}, orun, 0);
        check({tag, "_ur"}, urun, 0);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        sv    = 1'b0;
        l_in  = '0;
        r_in  = '0;
        repeat (3) tick();
        check_idle("rst");

        // Reset, first frame underrun of zeros; sample A arrives mid-frame.
        release_check("r1", 1'b0, F_ZERO);
        add_stim(5, F_A, 1'b1);
        run_frame("f1");

        // Single sample on the wire.
        do_load("ld2", 1'b0, 1'b0, F_ZERO);
        run_frame("f2");

        // Starvation: A repeats; meanwhile B1 then B2 overrun the buffer.
        do_load("ld3", 1'b1, 1'b0, F_ZERO);
        exp_q.push_back(F_A);
        snap = n_or;
        add_stim(3, F_B1, 1'b0);
        add_stim(40, F_B2, 1'b1);
        run_frame("f3");
        check("ovr_once", n_or - snap, 1);

        do_load("ld4", 1'b0, 1'b0, F_ZERO);
        run_frame("f4");

        // Strobe on the load cycle while empty: goes straight out.
        do_load("ld5", 1'b0, 1'b1, F_C);
        snap = n_or;
        add_stim(10, F_B3, 1'b1);
        run_frame("f5");

        // Strobe on the load cycle while full: B3 goes out, D is held.
        do_load("ld6", 1'b0, 1'b1, F_D);
        run_frame("f6");
        check("ovr_none", n_or - snap, 0);

        do_load("ld7", 1'b0, 1'b0, F_ZERO);
        run_frame("f7");

        // Repeat of D, interrupted by reset at p=10 while BCLK is high.
        do_load("ld8", 1'b1, 1'b0, F_ZERO);
        for (int p = 1; p <= 10; p++) begin
            wait_fall(ok);
            if (!ok) check("midrst_fall_timeout", 0, 1);
        end
        repeat (DIV) tick();
        check("pre_rst_bclk", bclk, 1);
        check("pre_rst_dat", dat, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        repeat (3) tick();
        check_idle("midrst_hold");
        exp_q.delete();
        stim_q.delete();

        // Timing restarts from scratch; sample E lands before the first load.
        release_check("r2", 1'b1, F_E);
        run_frame("fe1");
        do_load("lde2", 1'b1, 1'b0, F_ZERO);
        exp_q.push_back(F_E);
        run_frame("fe2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
